// File: rtl/sync_fifo1_enq_arbiter.sv
// Round-robin arbiter feeding the enqueue side of a single-entry CDC FIFO.
// Granted beats are staged in a holding register tagged {id, data}, so the
// destination domain can demultiplex them.
module sync_fifo1_enq_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [NUM_REQ-1:0]               i_req_mask,
  input  logic                             i_fifo_full_n,
  output logic                             o_fifo_enq,
  output logic [ID_WIDTH+DATA_WIDTH-1:0]   o_fifo_d_in,
  output logic                             o_hold_valid,
  output logic [15:0]                      o_enq_count
);

  localparam int unsigned WORD_W = ID_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W  = 16;
  localparam logic [ID_WIDTH:0]   NUM_REQ_X = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  logic                    r_hold_valid;
  logic [WORD_W-1:0]       r_hold_word;
  logic [ID_WIDTH-1:0]     r_ptr;
  logic [CNT_W-1:0]        r_enq_count;

  logic [NUM_REQ-1:0]      w_elig;
  logic [2*NUM_REQ-1:0]    w_dbl;
  logic [NUM_REQ-1:0]      w_rot;
  logic                    w_found;
  logic [ID_WIDTH:0]       w_off;
  logic [ID_WIDTH:0]       w_sum;
  logic [ID_WIDTH-1:0]     w_winner;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_enq;
  logic                    w_load;
  logic                    w_accept;

  // Handshake with the FIFO and the holding-register load condition.
  assign w_enq    = r_hold_valid & i_fifo_full_n;
  assign w_load   = ~r_hold_valid | w_enq;
  assign w_elig   = i_req_valid & ~i_req_mask;

  // Rotate eligibility so that bit 0 corresponds to the pointer position.
  assign w_dbl    = {w_elig, w_elig};
  assign w_rot    = NUM_REQ'(w_dbl >> r_ptr);

  // Lowest set bit of the rotated vector is the first eligible from ptr upward.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_rot[k] && !w_found) begin
        w_found = 1'b1;
        w_off   = (ID_WIDTH+1)'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute requester index.
  assign w_sum    = {1'b0, r_ptr} + w_off;
  assign w_winner = (w_sum >= NUM_REQ_X) ? ID_WIDTH'(w_sum - NUM_REQ_X)
                                         : ID_WIDTH'(w_sum);
  assign w_accept = w_load & w_found & ~i_rst;

  // Select the winning requester's payload.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_winner == ID_WIDTH'(k)) begin
        w_sel_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One-hot accept strobe back to the requesters.
  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      o_req_ready[k] = w_accept & (w_winner == ID_WIDTH'(k));
    end
  end

  // Holding register, round-robin pointer and enqueue counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_valid <= 1'b0;
      r_hold_word  <= '0;
      r_ptr        <= '0;
      r_enq_count  <= '0;
    end else begin
      if (w_enq) begin
        r_enq_count <= r_enq_count + CNT_W'(1);
      end
      if (w_accept) begin
        r_hold_word  <= {w_winner, w_sel_data};
        r_hold_valid <= 1'b1;
        r_ptr        <= (w_winner == LAST_ID) ? '0 : w_winner + ID_WIDTH'(1);
      end else if (w_enq) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign o_fifo_enq   = w_enq;
  assign o_fifo_d_in  = r_hold_word;
  assign o_hold_valid = r_hold_valid;
  assign o_enq_count  = r_enq_count;

endmodule

// File: tb/tb_sync_fifo1_enq_arbiter.sv
// Self-checking bench for sync_fifo1_enq_arbiter with a behavioural model.
module tb_sync_fifo1_enq_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_mask  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            full_n    = 1'b1;
  logic [N-1:0]    req_ready;
  logic            fifo_enq;
  logic [IW+DW-1:0] fifo_d_in;
  logic            hold_valid;
  logic [15:0]     enq_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit             m_hv;
  int             m_id;
  logic [DW-1:0]  m_data;
  int             m_ptr;
  int             m_count;
  bit             m_found;
  int             m_win;
  bit             e_enq;
  logic [N-1:0]   e_ready;
  logic [IW+DW-1:0] e_dout;

  sync_fifo1_enq_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_req_mask(req_mask), .i_fifo_full_n(full_n),
    .o_fifo_enq(fifo_enq), .o_fifo_d_in(fifo_d_in), .o_hold_valid(hold_valid),
    .o_enq_count(enq_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    m_hv = 1'b0; m_id = 0; m_data = '0; m_ptr = 0; m_count = 0;
  endfunction

  // Expected combinational outputs from the current model state and inputs.
  function automatic void model_eval();
    bit load;
    e_enq   = m_hv && full_n;
    load    = !m_hv || e_enq;
    m_found = 1'b0;
    m_win   = 0;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (m_ptr + off) % N;
      if (!m_found && req_valid[idx] && !req_mask[idx]) begin
        m_found = 1'b1;
        m_win   = idx;
      end
    end
    e_ready = '0;
    if (load && m_found && !rst) e_ready[m_win] = 1'b1;
    e_dout = {IW'(m_id), m_data};
  endfunction

  // Advance one clock, updating the model with what happened at the edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (e_enq) m_count = (m_count + 1) % 65536;
      if (|e_ready) begin
        m_id   = m_win;
        m_data = req_data[m_win*DW +: DW];
        m_hv   = 1'b1;
        m_ptr  = (m_win + 1) % N;
      end else if (e_enq) begin
        m_hv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_reset();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2;
    req_valid = '1;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    full_n    = 1'b1;
    rst       = 1'b1;
    m_reset();
    #1;
    checks++;
    if ({req_ready, fifo_enq, fifo_d_in, hold_valid, enq_count} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b enq=%b din=%h hv=%b cnt=%h exp all zero",
               req_ready, fifo_enq, fifo_d_in, hold_valid, enq_count);
    end
    repeat (2) begin
      tick();
      checks++;
      if (req_ready !== '0 || fifo_enq !== 1'b0 || hold_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got rdy=%b enq=%b hv=%b exp 0/0/0", req_ready, fifo_enq, hold_valid);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b exp 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_single();
    req_mask = '0;
    full_n   = 1'b1;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    req_data[2*DW +: DW] = 32'hA5A5A5A5;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || fifo_enq !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got rdy=%b enq=%b exp 0100/0", req_ready, fifo_enq);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== '0 || fifo_enq !== 1'b1 || fifo_d_in !== {2'd2, 32'hA5A5A5A5} || hold_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_enq: got rdy=%b enq=%b din=%h hv=%b exp 0000/1/2a5a5a5a5/1",
               req_ready, fifo_enq, fifo_d_in, hold_valid);
    end
    tick();
    checks++;
    if (enq_count !== 16'd1 || fifo_enq !== 1'b0 || hold_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_count: got cnt=%h enq=%b hv=%b exp 0001/0/0", enq_count, fifo_enq, hold_valid);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
    int hc = 0;
    logic [N-1:0] rdy;
    apply_reset();
    req_mask  = '0;
    req_valid = '1;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 0; cyc < 200 && ids.size() < 6; cyc++) begin
      full_n = (hc == 0);
      #1;
      model_eval();
      checks++;
      if ({req_ready, fifo_enq, fifo_d_in, hold_valid, enq_count} !==
          {e_ready, e_enq, e_dout, m_hv, 16'(m_count)}) begin
        errors++;
        $display("FAIL rr_model cyc %0d: got rdy=%b enq=%b din=%h hv=%b cnt=%h exp rdy=%b enq=%b din=%h hv=%b cnt=%h",
                 cyc, req_ready, fifo_enq, fifo_d_in, hold_valid, enq_count,
                 e_ready, e_enq, e_dout, m_hv, 16'(m_count));
      end
      if (fifo_enq === 1'b1) ids.push_back(int'(fifo_d_in[IW+DW-1 -: IW]));
      if (fifo_enq === 1'b1) hc = 3;
      else if (hc > 0) hc--;
      rdy = req_ready;
      tick();
      for (int k = 0; k < N; k++) if (rdy[k]) req_data[k*DW +: DW] = $urandom;
    end
    checks++;
    if (ids.size() != 6) begin
      errors++;
      $display("FAIL rr_timeout: got %0d enqueues exp 6", ids.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ids[i] != exp_ids[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got id %0d exp %0d", i, ids[i], exp_ids[i]);
        end
      end
    end
  endtask

  task automatic test_mask();
    int ids[$];
    int exp_ids[9] = '{0, 2, 3, 0, 2, 3, 0, 1, 2};
    apply_reset();
    full_n    = 1'b1;
    req_mask  = 4'b0010;
    req_valid = '1;
    for (int cyc = 0; cyc < 100 && ids.size() < 9; cyc++) begin
      req_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      model_eval();
      checks++;
      if ({req_ready, fifo_enq, fifo_d_in, hold_valid} !== {e_ready, e_enq, e_dout, m_hv}) begin
        errors++;
        $display("FAIL mask_model cyc %0d: got rdy=%b enq=%b din=%h exp rdy=%b enq=%b din=%h",
                 cyc, req_ready, fifo_enq, fifo_d_in, e_ready, e_enq, e_dout);
      end
      if (fifo_enq === 1'b1) ids.push_back(int'(fifo_d_in[IW+DW-1 -: IW]));
      if (ids.size() == 5) req_mask = '0;
      tick();
    end
    checks++;
    if (ids.size() != 9) begin
      errors++;
      $display("FAIL mask_timeout: got %0d enqueues exp 9", ids.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (ids[i] != exp_ids[i]) begin
          errors++;
          $display("FAIL mask_order[%0d]: got id %0d exp %0d", i, ids[i], exp_ids[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0, d1;
    apply_reset();
    req_mask  = '0;
    full_n    = 1'b0;
    req_valid = '1;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    d0 = req_data[0 +: DW];
    d1 = req_data[DW +: DW];
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_first_accept: got %b exp 0001", req_ready);
    end
    tick();
    req_data[0 +: DW] = ~d0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (fifo_enq !== 1'b0 || fifo_d_in !== {2'd0, d0} || req_ready !== '0 || hold_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got enq=%b din=%h rdy=%b hv=%b exp 0/%h/0000/1",
                 i, fifo_enq, fifo_d_in, req_ready, hold_valid, {2'd0, d0});
      end
      tick();
    end
    full_n = 1'b1;
    #1;
    checks++;
    if (fifo_enq !== 1'b1 || fifo_d_in !== {2'd0, d0} || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: got enq=%b din=%h rdy=%b exp 1/%h/0010",
               fifo_enq, fifo_d_in, req_ready, {2'd0, d0});
    end
    tick();
    checks++;
    if (fifo_d_in !== {2'd1, d1} || hold_valid !== 1'b1 || enq_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_after: got din=%h hv=%b cnt=%h exp %h/1/0001",
               fifo_d_in, hold_valid, enq_count, {2'd1, d1});
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = N'($urandom);
      req_mask  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      full_n    = ($urandom_range(0, 3) != 0);
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      model_eval();
      checks++;
      if ({req_ready, fifo_enq, fifo_d_in, hold_valid, enq_count} !==
          {e_ready, e_enq, e_dout, m_hv, 16'(m_count)}) begin
        errors++;
        $display("FAIL random cyc %0d: got rdy=%b enq=%b din=%h hv=%b cnt=%h exp rdy=%b enq=%b din=%h hv=%b cnt=%h",
                 cyc, req_ready, fifo_enq, fifo_d_in, hold_valid, enq_count,
                 e_ready, e_enq, e_dout, m_hv, 16'(m_count));
      end
      tick();
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    req_mask  = '0;
    req_valid = '1;
    full_n    = 1'b1;
    repeat (65537) tick();
    checks++;
    if (enq_count !== 16'h0000 || 16'(m_count) !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero: got cnt=%h model=%h exp 0000", enq_count, 16'(m_count));
    end
    tick();
    checks++;
    if (enq_count !== 16'h0001 || hold_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_one: got cnt=%h hv=%b exp 0001/1", enq_count, hold_valid);
    end
    full_n = 1'b0;
    rst    = 1'b1;
    m_reset();
    #1;
    checks++;
    if (hold_valid !== 1'b0 || fifo_enq !== 1'b0 || req_ready !== '0 || enq_count !== 16'h0000) begin
      errors++;
      $display("FAIL midop_reset: got hv=%b enq=%b rdy=%b cnt=%h exp 0/0/0000/0000",
               hold_valid, fifo_enq, req_ready, enq_count);
    end
    tick();
    rst       = 1'b0;
    req_valid = '0;
    full_n    = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (fifo_enq !== 1'b0 || enq_count !== 16'h0000 || hold_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_discard: got enq=%b cnt=%h hv=%b exp 0/0000/0", fifo_enq, enq_count, hold_valid);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_backpressure();
    test_random();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo1_enq_arbiter.md
# sync_fifo1_enq_arbiter

Round-robin arbiter that shares the enqueue side of one single-entry clock-domain-crossing FIFO among `NUM_REQ` requesters in the source clock domain. It sits between the requesters and the FIFO's source-side ports (`sENQ`, `sD_IN`, `sFULL_N`). It registers each granted beat and tags it with the requester index, so the destination domain can demultiplex it. It also provides a per-requester mask and a wrapping enqueue counter for configuration and debug.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..16.
- `DATA_WIDTH`, default 32: payload width per requester.
- `ID_WIDTH`, default 2: tag width; must satisfy 2^`ID_WIDTH` ≥ `NUM_REQ`.
- `CLK`  in  1  source-domain clock, the same clock as the FIFO's `sCLK`; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ_VALID`  in  `NUM_REQ`  bit i: requester i has a beat.
- `REQ_DATA`  in  `NUM_REQ`*`DATA_WIDTH`  requester i payload in bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `REQ_READY`  out  `NUM_REQ`  one-hot (or zero) accept strobe.
- `REQ_MASK`  in  `NUM_REQ`  bit i = 1 excludes requester i from arbitration.
- `FIFO_FULL_N`  in  1  from the FIFO's `sFULL_N`.
- `FIFO_ENQ`  out  1  to the FIFO's `sENQ`.
- `FIFO_D_IN`  out  `ID_WIDTH`+`DATA_WIDTH`  to the FIFO's `sD_IN`; layout {id, data}.
- `HOLD_VALID`  out  1  holding register occupied.
- `ENQ_COUNT`  out  16  number of beats enqueued, modulo 2^16.

## Operation
- Holding register: `hold_valid` and `hold_word` = {id, data}.
- `FIFO_ENQ` = `hold_valid` & `FIFO_FULL_N`, combinational. `FIFO_D_IN` = `hold_word`.
- Load enable: `load` = !`hold_valid` | `FIFO_ENQ`.
- Eligible vector: `elig` = `REQ_VALID` & ~`REQ_MASK`.
- Winner `w`:
  - Scan `elig` starting at pointer `ptr` and moving upward, wrapping from `NUM_REQ`-1 to 0.
  - `w` is the first set bit found.
  - There is no winner if `elig` = 0.
- `REQ_READY`:
  - When `load` is high and a winner exists, `REQ_READY` = one-hot(`w`).
  - Otherwise `REQ_READY` = 0. It is combinational.
- On an accept (`load` & winner exists):
  - `hold_word` ← {`w`, `REQ_DATA`[w]}.
  - `hold_valid` ← 1.
  - `ptr` ← `w`+1, or 0 if `w` = `NUM_REQ`-1.
- On `FIFO_ENQ` with no accept in the same cycle: `hold_valid` ← 0. `hold_word` keeps its value.
- Simultaneous `FIFO_ENQ` and accept: the old beat goes to the FIFO and the new beat replaces it in the same edge.
- `ptr` changes only on an accept. A masked or idle requester never advances `ptr`.
- `REQ_MASK` changes take effect in arbitration in the same cycle. A beat already in the holding register is always delivered, even if its requester is masked afterwards.
- Requesters hold `REQ_VALID` and data until `REQ_READY`. The arbiter keeps no per-requester state, so a dropped `REQ_VALID` is simply not granted.
- `ENQ_COUNT` increments by 1 on every cycle with `FIFO_ENQ` = 1 and wraps from 0xFFFF to 0x0000.
- `FIFO_FULL_N` is low while the FIFO is in reset and during its synchronisation latency. The arbiter still accepts one beat into the holding register and holds it there.

## Timing
- Reset values (asynchronous, immediate on `RST` = 1):
  - `hold_valid` = 0, `hold_word` = 0, `ptr` = 0, `ENQ_COUNT` = 0.
  - Hence `FIFO_ENQ` = 0, `FIFO_D_IN` = 0, `HOLD_VALID` = 0.
  - `REQ_READY` = 0 while `RST` = 1.
- Latency:
  - Accept at edge k gives `HOLD_VALID` = 1 after k.
  - `FIFO_ENQ` goes high in cycle k+1 if `FIFO_FULL_N` = 1. Minimum latency is one cycle.
- Backpressure: while `hold_valid` = 1 and `FIFO_FULL_N` = 0:
  - `FIFO_D_IN` is stable.
  - `REQ_READY` = 0.
  - No requester is accepted.
- Throughput is bounded by the FIFO's round-trip synchronisation. The arbiter never issues `FIFO_ENQ` while `FIFO_FULL_N` = 0.
- Reset mid-operation: a beat in the holding register is discarded. It is not counted and not enqueued. After release, arbitration restarts at requester 0.

## Test plan
- Reset:
  - Assert `RST` with all `REQ_VALID` = 1.
  - Required: `REQ_READY` = 0, `FIFO_ENQ` = 0, `FIFO_D_IN` = 0, `ENQ_COUNT` = 0.
  - After release, requester 0 is granted first.
- Single requester:
  - `REQ_VALID` = 0b0100 with data 0xA5A5A5A5, `FIFO_FULL_N` = 1.
  - Required: `REQ_READY` = 0b0100 for one cycle.
  - Next cycle: `FIFO_ENQ` = 1 with `FIFO_D_IN` = {2'd2, 0xA5A5A5A5}, and `ENQ_COUNT` = 1.
- Round robin:
  - All four requesters valid continuously. Model `FIFO_FULL_N` as low for 3 cycles after each `FIFO_ENQ`.
  - Required: enqueued ids 0,1,2,3,0,1 in that order, with no id repeated out of turn.
- Mask:
  - All valid, `REQ_MASK` = 0b0010.
  - Required: id sequence 0,2,3,0,2.
  - Clearing the mask mid-stream puts 1 back into the rotation at its next turn.
- Backpressure:
  - Holding register full, `FIFO_FULL_N` = 0 for 10 cycles.
  - Required: `FIFO_ENQ` = 0, `FIFO_D_IN` constant, `REQ_READY` = 0 throughout.
  - The beat is enqueued in the first cycle `FIFO_FULL_N` = 1, with an accept in the same cycle.
- Counter wrap and reset:
  - Issue 65,537 enqueues. Required: `ENQ_COUNT` = 0x0001.
  - Assert `RST` while `HOLD_VALID` = 1. Required: `HOLD_VALID` = 0 immediately and no `FIFO_ENQ` for that beat.
